vending_fsm_param: RTL

Parametrised coin-operated vending controller for the chocolate-machine lab designs. It accepts 50- and 100-unit coins, including both in the same cycle, against a configurable price. It dispenses, returns change one 50-unit coin per cycle, supports cancel/refund, rejects coins while busy, and counts sales. It sits between the coin-sensor synchronisers and the dispenser/change-hopper drivers.

---
 rtl/vending_fsm_param.sv | 84 ++++++++
 1 files changed

// File: rtl/vending_fsm_param.sv
// rtl/vending_fsm_param.sv - coin-operated vending controller with configurable price
// Accepts 50/100-unit coins, dispenses, pays change one coin per cycle, counts sales.
module vending_fsm_param #(
    parameter int PRICE_UNITS = 4,
    parameter int CREDIT_W    = 4,
    parameter int SALES_W     = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in50,
    input  logic                in100,
    input  logic                cancel,
    output logic                dispense,
    output logic                change50,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [SALES_W-1:0]  sales_count
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    localparam logic [CREDIT_W:0] PRICE = (CREDIT_W+1)'(PRICE_UNITS);

    state_t              state;
    logic [1:0]          value;
    logic                coin_present;
    logic [CREDIT_W:0]   sum;

    // One extra bit so credit plus a double coin never wraps before the price compare.
    assign value        = {in100, in50};
    assign coin_present = in50 | in100;
    assign sum          = {1'b0, credit} + (CREDIT_W+1)'(value);
    assign busy         = (state != COLLECT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= COLLECT;
            credit      <= '0;
            sales_count <= '0;
            dispense    <= 1'b0;
            change50    <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            dispense    <= 1'b0;
            change50    <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                COLLECT: begin
                    if (cancel && credit != '0) begin
                        state       <= CHANGE;
                        change50    <= 1'b1;
                        credit      <= credit - CREDIT_W'(1);
                        coin_reject <= coin_present;
                    end else if (sum < PRICE) begin
                        credit <= sum[CREDIT_W-1:0];
                    end else begin
                        credit      <= CREDIT_W'(sum - PRICE);
                        dispense    <= 1'b1;
                        sales_count <= sales_count + SALES_W'(1);
                        state       <= DISPENSE;
                    end
                end
                DISPENSE, CHANGE: begin
                    // Coins arriving while busy are bounced back by the hopper hardware.
                    coin_reject <= coin_present;
                    if (credit != '0) begin
                        change50 <= 1'b1;
                        credit   <= credit - CREDIT_W'(1);
                        state    <= CHANGE;
                    end else begin
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
